// File: rtl/signmag_decoder.sv
// -----------------------------------------------------------------------------
// signmag_decoder
//
// Converts a stream of W-bit two's-complement results back into sign-magnitude
// form (sign bit + unsigned magnitude) so they can be re-fed to the subtracter
// as operands or displayed. A 2-entry FIFO decouples the valid/ready handshakes
// on both sides, and a saturating counter tracks accepted negative inputs.
//
// Ports:
//   clk        sole clock, rising edge
//   Reset      synchronous, active-low reset
//   Diff       W-bit two's-complement input value
//   in_valid   Diff is valid
//   in_ready   block can accept (registered, independent of out_ready)
//   out_valid  head entry is valid
//   out_ready  consumer accepts head entry
//   Sign       head sign, 1 = negative
//   Mag        head magnitude, unsigned, 0..2^(W-1)
//   Ovf        head magnitude exceeds 2^OPW - 1
//   NegCount   saturating count of accepted negative inputs
// -----------------------------------------------------------------------------
module signmag_decoder #(
  parameter int W    = 6,
  parameter int OPW  = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [W-1:0]    Diff,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            Sign,
  output logic [W-1:0]    Mag,
  output logic            Ovf,
  output logic [CNTW-1:0] NegCount
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
    logic         ovf;
  } entry_t;

  localparam logic [W-1:0]    MAG_LIMIT = W'((1 << OPW) - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  state_t state, state_next;
  entry_t head, tail;
  entry_t conv;
  logic   accept, pop;

  // Conversion of the incoming value. Negating in W bits keeps -2^(W-1) at
  // 2^(W-1) (the unsigned reading of the same bit pattern) rather than 0.
  always_comb begin
    conv.sign = Diff[W-1];
    conv.mag  = conv.sign ? (~Diff + W'(1)) : Diff;
    conv.ovf  = (conv.mag > MAG_LIMIT);
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign Sign = head.sign;
  assign Mag  = head.mag;
  assign Ovf  = head.ovf;

  // NOTE: every variable written here gets a default first so no path through
  // the case can leave it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY:   if (accept) state_next = ONE;
      ONE:     if (accept && !pop) state_next = FULL;
               else if (pop && !accept) state_next = EMPTY;
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!Reset) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: the buffer is reset too, because the head entry drives Sign/Mag/Ovf
  // directly and those must read zero after reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      // New data lands in the head slot when the buffer is empty or the head
      // is leaving this cycle; otherwise it queues behind the head.
      if (accept && (state == EMPTY || pop)) head <= conv;
      else if (pop && state == FULL)         head <= tail;

      if (accept && state == ONE && !pop)    tail <= conv;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset)                                        NegCount <= '0;
    else if (accept && Diff[W-1] && NegCount != CNT_MAX) NegCount <= NegCount + CNTW'(1);
  end

endmodule

// File: tb/tb_signmag_decoder.sv
// -----------------------------------------------------------------------------
// tb_signmag_decoder
//
// Self-checking bench for signmag_decoder. A queue-based model holds the
// expected buffer contents as plain integers (sign, |value|, overflow) and a
// saturating integer tracks the negative count.
// -----------------------------------------------------------------------------
module tb_signmag_decoder;

  localparam int W    = 6;
  localparam int OPW  = 4;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            Reset;
  logic [W-1:0]    Diff;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic            Sign;
  logic [W-1:0]    Mag;
  logic            Ovf;
  logic [CNTW-1:0] NegCount;

  signmag_decoder #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Diff     (Diff),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sign     (Sign),
    .Mag      (Mag),
    .Ovf      (Ovf),
    .NegCount (NegCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sign;
    int mag;
    bit ovf;
  } ent_t;

  ent_t mq[$];
  int   neg_cnt;
  int   checks;
  int   errors;

  // Reference conversion straight from the arithmetic meaning of the value.
  function automatic ent_t ref_conv(input int v);
    ent_t e;
    e.sign = (v < 0);
    e.mag  = (v < 0) ? -v : v;
    e.ovf  = (e.mag > (2 ** OPW - 1));
    return e;
  endfunction

  // Expected {out_valid, in_ready, Sign, Mag, Ovf, NegCount}; data fields are
  // only defined while the model holds an entry.
  function automatic logic [17:0] exp_vec();
    ent_t h;
    h = '{sign: 1'b0, mag: 0, ovf: 1'b0};
    if (mq.size() > 0) h = mq[0];
    return {mq.size() != 0, mq.size() < 2, h.sign, 6'(h.mag), h.ovf, 8'(neg_cnt)};
  endfunction

  function automatic logic [17:0] obs_vec();
    logic [7:0] d;
    d = {Sign, Mag, Ovf};
    if (mq.size() == 0) d = '0;
    return {out_valid, in_ready, d, NegCount};
  endfunction

  // One clock of stimulus; the model decides acceptance and pops from its own
  // occupancy and is updated at the edge. Returns whether the model accepted.
  task automatic step(input bit v, input int value, input bit r, output bit acc);
    bit pop;
    in_valid  = v;
    Diff      = W'(value);
    out_ready = r;
    acc = v && (mq.size() < 2);
    pop = r && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(ref_conv(value));
      if (value < 0 && neg_cnt < 2 ** CNTW - 1) neg_cnt++;
    end
  endtask

  task automatic do_reset(input bit junk);
    Reset     = 1'b0;
    in_valid  = junk;
    out_ready = junk;
    Diff      = W'($urandom);
    @(posedge clk);
    #1;
    Reset    = 1'b1;
    in_valid = 1'b0;
    mq.delete();
    neg_cnt = 0;
  endtask

  function automatic int rand_val();
    return int'($urandom_range(63)) - 32;
  endfunction

  task automatic test_reset();
    do_reset(1'b1);
    do_reset(1'b1);
    checks++;
    if ({out_valid, in_ready, Sign, Mag, Ovf, NegCount} !== {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got %h required %h",
               {out_valid, in_ready, Sign, Mag, Ovf, NegCount}, {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_basic();
    bit acc;
    int vals[2] = '{-12, 0};
    bit vlds[2] = '{1'b1, 1'b0};
    do_reset(1'b0);
    for (int i = 0; i < 2; i++) begin
      step(vlds[i], vals[i], 1'b1, acc);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_neg12 cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int vals[3] = '{-32, 21, 0};
    bit vlds[3] = '{1'b1, 1'b1, 1'b0};
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(vlds[i], vals[i], 1'b1, acc);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_zero();
    bit acc;
    int vals[3] = '{0, 15, 0};
    bit vlds[3] = '{1'b1, 1'b1, 1'b0};
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(vlds[i], vals[i], 1'b1, acc);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL zero_and_15 cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int vals[3] = '{-2, -3, -4};
    int idx = 0;
    do_reset(1'b0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(idx < 3, vals[(idx < 3) ? idx : 0], cyc >= 6, acc);
      if (acc) idx++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
      if (cyc >= 1 && cyc <= 5) begin
        checks++;
        if ({out_valid, in_ready, Sign, Mag} !== {1'b1, 1'b0, 1'b1, 6'd2}) begin
          errors++;
          $display("FAIL backpressure_hold cycle %0d: got %h required %h",
                   cyc, {out_valid, in_ready, Sign, Mag}, {1'b1, 1'b0, 1'b1, 6'd2});
        end
      end
    end
    checks++;
    if (NegCount !== 8'd3) begin
      errors++;
      $display("FAIL backpressure_negcount: got %0d required 3", NegCount);
    end
  endtask

  task automatic test_saturation();
    bit acc;
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, -(1 + int'($urandom_range(31))), 1'b1, acc);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturation cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (NegCount !== 8'd255) begin
      errors++;
      $display("FAIL saturation_final: got %0d required 255", NegCount);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, -(i + 1), 1'b1, acc);
    step(1'b0, 0, 1'b1, acc);
    step(1'b1, -5, 1'b0, acc);
    step(1'b1, -6, 1'b0, acc);
    checks++;
    if ({out_valid, in_ready, NegCount} !== {1'b1, 1'b0, 8'd5}) begin
      errors++;
      $display("FAIL reset_mid_prefill: got %h required %h",
               {out_valid, in_ready, NegCount}, {1'b1, 1'b0, 8'd5});
    end
    // Reset must win over a simultaneous offer and pop.
    Reset     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    Diff      = W'(-9);
    @(posedge clk);
    #1;
    Reset    = 1'b1;
    in_valid = 1'b0;
    mq.delete();
    neg_cnt = 0;
    checks++;
    if ({out_valid, in_ready, Sign, Mag, Ovf, NegCount} !== {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_state: got %h required %h",
               {out_valid, in_ready, Sign, Mag, Ovf, NegCount}, {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0});
    end
    step(1'b1, -7, 1'b1, acc);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_accept: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, rand_val(), $urandom_range(2) != 0, acc);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    neg_cnt   = 0;
    Reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Diff      = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
